// File: rtl/pack_arbiter_if.sv
// Handshake bundle between the byte-stream sources, the packet arbiter and the packer.
// The arbiter sits on the slave modport; the sources/packer side uses master.
interface pack_arbiter_if #(
  parameter int NUM_SRC        = 4,
  parameter int SIZE_INPUT_BIT = 8
);
  logic [NUM_SRC-1:0]                i_valid;
  logic [NUM_SRC*SIZE_INPUT_BIT-1:0] i_data;
  logic [NUM_SRC-1:0]                o_ready;
  logic [SIZE_INPUT_BIT-1:0]         o_data;
  logic                              o_valid;
  logic                              i_ready_pack;
  logic [NUM_SRC-1:0]                o_grant;
  logic                              o_pkt_done;
  logic                              o_padded;

  modport master (
    output i_valid, i_data, i_ready_pack,
    input  o_ready, o_data, o_valid, o_grant, o_pkt_done, o_padded
  );

  modport slave (
    input  i_valid, i_data, i_ready_pack,
    output o_ready, o_data, o_valid, o_grant, o_pkt_done, o_padded
  );
endinterface

// File: rtl/pack_arbiter.sv
// Round-robin packet arbiter: one source owns a fixed-length packet at a time, and a
// starving owner is replaced by fill words so every packet completes at full length.
module pack_arbiter #(
  parameter int                        NUM_SRC        = 4,
  parameter int                        SIZE_INPUT_BIT = 8,
  parameter int                        PAYLOAD_WORDS  = 243,
  parameter int                        TIMEOUT_CYCLES = 16,
  parameter logic [SIZE_INPUT_BIT-1:0] FILL_WORD      = 8'h00
) (
  input logic           i_clk,
  input logic           i_reset_n,
  pack_arbiter_if.slave bus
);
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_WORD    = CW'(PAYLOAD_WORDS - 1);
  localparam logic [SW-1:0] STARVE_LIMIT = SW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW:0]   NUM_SRC_W    = (IW + 1)'(NUM_SRC);

  typedef enum logic [1:0] {IDLE, XFER, PAD} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic [IW-1:0]      last_idx;
  logic [CW-1:0]      word_cnt;
  logic [SW-1:0]      starve_cnt;

  logic                      req_found;
  logic [IW-1:0]             req_idx;
  logic [IW:0]               cand;
  logic                      src_valid;
  logic [SIZE_INPUT_BIT-1:0] src_data;
  logic                      out_valid;
  logic [SIZE_INPUT_BIT-1:0] out_data;
  logic [NUM_SRC-1:0]        out_ready;
  logic                      xfer;
  logic                      last_word;

  // Scan sources starting one past the previous owner so every requester gets a turn.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = {1'b0, last_idx} + (IW + 1)'(k);
      if (cand >= NUM_SRC_W) begin
        cand = cand - NUM_SRC_W;
      end
      if (!req_found && bus.i_valid[cand[IW-1:0]]) begin
        req_found = 1'b1;
        req_idx   = cand[IW-1:0];
      end
    end
  end

  assign src_valid = bus.i_valid[grant_idx];
  assign src_data  = bus.i_data[int'(grant_idx) * SIZE_INPUT_BIT +: SIZE_INPUT_BIT];

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_ready = '0;
    case (state)
      XFER: begin
        out_valid = src_valid;
        out_data  = src_data;
        out_ready = bus.i_ready_pack ? grant : '0;
      end
      PAD: begin
        out_valid = 1'b1;
        out_data  = FILL_WORD;
      end
      default: ;
    endcase
  end

  assign xfer      = out_valid && bus.i_ready_pack;
  assign last_word = (word_cnt == LAST_WORD);

  assign bus.o_valid    = out_valid;
  assign bus.o_data     = out_data;
  assign bus.o_ready    = out_ready;
  assign bus.o_grant    = grant;
  assign bus.o_pkt_done = xfer && last_word;
  assign bus.o_padded   = xfer && last_word && (state == PAD);

  // Starvation only counts cycles where the owner has nothing; packer backpressure is not its fault.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      grant_idx  <= '0;
      last_idx   <= IW'(NUM_SRC - 1);
      word_cnt   <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_found) begin
            grant      <= NUM_SRC'(1) << req_idx;
            grant_idx  <= req_idx;
            last_idx   <= req_idx;
            word_cnt   <= '0;
            starve_cnt <= '0;
            state      <= XFER;
          end
        end
        XFER: begin
          if (xfer) begin
            starve_cnt <= '0;
            if (last_word) begin
              grant <= '0;
              state <= IDLE;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end else if (src_valid) begin
            starve_cnt <= '0;
          end else if (starve_cnt == STARVE_LIMIT) begin
            grant      <= '0;
            starve_cnt <= '0;
            state      <= PAD;
          end else begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        PAD: begin
          if (xfer) begin
            if (last_word) begin
              state <= IDLE;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pack_arbiter.sv
// Directed bench for pack_arbiter: a vector table for cycle-level behaviour, then
// whole-packet sequences for round-robin, starvation padding, backpressure and mid-packet reset.
module tb_pack_arbiter;
  localparam int         NUM_SRC = 4;
  localparam int         W       = 8;
  localparam int         PAYLOAD = 243;
  localparam int         TIMEOUT = 16;
  localparam logic [7:0] FILL    = 8'hA5;
  localparam int         NONE    = 1 << 30;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pack_arbiter_if #(.NUM_SRC(NUM_SRC), .SIZE_INPUT_BIT(W)) bus ();

  pack_arbiter #(
    .NUM_SRC(NUM_SRC), .SIZE_INPUT_BIT(W), .PAYLOAD_WORDS(PAYLOAD),
    .TIMEOUT_CYCLES(TIMEOUT), .FILL_WORD(FILL)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        rp;
    logic [3:0]  grant;
    logic        ovalid;
    logic [7:0]  odata;
    logic [3:0]  ready;
    logic        done;
  } vec_t;

  vec_t vecs[10];
  int   checks   = 0;
  int   failures = 0;
  int   word_cnt[NUM_SRC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Each source emits a distinct running byte sequence so reordering or skips show up.
  function automatic logic [7:0] data_of(input int k);
    return 8'(word_cnt[k] + k * 61);
  endfunction

  task automatic drive_sources(input logic [NUM_SRC-1:0] v);
    bus.i_valid = v;
    for (int k = 0; k < NUM_SRC; k++) bus.i_data[k*W +: W] = data_of(k);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_valid = '0;
    bus.i_ready_pack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_packet(input string tag, input int src, input logic [NUM_SRC-1:0] others,
                            input int drop_after, input int stall_at, input int stall_len,
                            input bit exp_pad, input logic [NUM_SRC-1:0] after);
    int nxfer = 0, bad = 0, cyc = 0, stall_left = 0, sent = 0, pad_words = 0;
    int last_src_cyc = -1, first_pad_cyc = -1;
    bit granted = 0, done = 0, padded = 0, stalled = 0;
    logic [NUM_SRC-1:0] v;
    logic [NUM_SRC-1:0] mask;
    mask = '0;
    mask[src] = 1'b1;
    while (!done && cyc < 3000) begin
      v = others;
      v[src] = (sent < drop_after);
      if (!stalled && stall_len > 0 && nxfer == stall_at) begin
        stalled = 1;
        stall_left = stall_len;
      end
      bus.i_ready_pack = (stall_left == 0);
      drive_sources(v);
      #1;
      if (!granted && bus.o_grant != '0) begin
        granted = 1;
        check({tag, " grant"}, 32'(bus.o_grant), 32'(mask));
      end
      if (stall_left > 0) begin
        if (bus.o_ready !== '0 || bus.o_grant !== mask) bad++;
        stall_left--;
      end
      if (bus.o_valid && bus.i_ready_pack) begin
        if (bus.o_grant != '0) begin
          if (bus.o_data !== data_of(src)) bad++;
        end else begin
          if (bus.o_data !== FILL) bad++;
          pad_words++;
          if (first_pad_cyc < 0) first_pad_cyc = cyc;
        end
        nxfer++;
      end
      for (int k = 0; k < NUM_SRC; k++) begin
        if (k != src && bus.o_ready[k]) bad++;
      end
      if (bus.o_ready[src] && v[src]) begin
        word_cnt[src]++;
        sent++;
        last_src_cyc = cyc;
      end
      if (bus.o_pkt_done) begin
        done = 1;
        padded = bus.o_padded;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " done seen"}, 32'(done), 32'd1);
    check({tag, " words"}, nxfer, PAYLOAD);
    check({tag, " data/ready errors"}, bad, 0);
    check({tag, " padded"}, 32'(padded), 32'(exp_pad));
    if (drop_after < PAYLOAD) begin
      check({tag, " pad words"}, pad_words, PAYLOAD - drop_after);
      check({tag, " pad start delay"}, first_pad_cyc - last_src_cyc, TIMEOUT + 1);
    end
    bus.i_ready_pack = 1'b1;
    drive_sources(after);
    #1;
    check({tag, " idle grant"}, 32'(bus.o_grant), 32'd0);
    check({tag, " idle valid"}, 32'(bus.o_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, cyc;
    for (int k = 0; k < NUM_SRC; k++) word_cnt[k] = 0;
    bus.i_valid = '0;
    bus.i_data = '0;
    bus.i_ready_pack = 1'b1;

    vecs[0] = '{1'b0, 4'b1111, 32'h44332211, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    vecs[1] = '{1'b1, 4'b1111, 32'h44332211, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    vecs[2] = '{1'b1, 4'b1111, 32'h44332211, 1'b1, 4'b0001, 1'b1, 8'h11, 4'b0001, 1'b0};
    vecs[3] = '{1'b1, 4'b1111, 32'h44332211, 1'b0, 4'b0001, 1'b1, 8'h11, 4'b0000, 1'b0};
    vecs[4] = '{1'b1, 4'b1110, 32'h44332211, 1'b1, 4'b0001, 1'b0, 8'h11, 4'b0001, 1'b0};
    vecs[5] = '{1'b1, 4'b1111, 32'h44332255, 1'b1, 4'b0001, 1'b1, 8'h55, 4'b0001, 1'b0};
    vecs[6] = '{1'b0, 4'b1111, 32'h44332255, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    vecs[7] = '{1'b1, 4'b0100, 32'h44332255, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    vecs[8] = '{1'b1, 4'b0100, 32'h44332255, 1'b1, 4'b0100, 1'b1, 8'h33, 4'b0100, 1'b0};
    vecs[9] = '{1'b1, 4'b0100, 32'h44332255, 1'b0, 4'b0100, 1'b1, 8'h33, 4'b0000, 1'b0};

    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      rst_n = vecs[i].rst_n;
      bus.i_valid = vecs[i].valid;
      bus.i_data = vecs[i].data;
      bus.i_ready_pack = vecs[i].rp;
      #1;
      check($sformatf("vec%0d grant", i), 32'(bus.o_grant), 32'(vecs[i].grant));
      check($sformatf("vec%0d valid", i), 32'(bus.o_valid), 32'(vecs[i].ovalid));
      check($sformatf("vec%0d data", i), 32'(bus.o_data), 32'(vecs[i].odata));
      check($sformatf("vec%0d ready", i), 32'(bus.o_ready), 32'(vecs[i].ready));
      check($sformatf("vec%0d done", i), 32'(bus.o_pkt_done), 32'(vecs[i].done));
      @(posedge clk);
      #1;
    end

    do_reset();
    run_packet("single", 0, 4'b0000, NONE, -1, 0, 1'b0, 4'b0000);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_packet($sformatf("rr%0d", i), (i % 2 == 1) ? 2 : 0, 4'b0101, NONE, -1, 0, 1'b0,
                 (i < 3) ? 4'b0101 : 4'b0000);
    end

    run_packet("starve", 1, 4'b0000, 100, -1, 0, 1'b1, 4'b0000);
    run_packet("stall", 3, 4'b0000, NONE, 100, 50, 1'b0, 4'b0000);

    sent = 0;
    cyc = 0;
    bus.i_ready_pack = 1'b1;
    while (sent < 120 && cyc < 1000) begin
      drive_sources(4'b0010);
      #1;
      if (bus.o_ready[1]) begin
        word_cnt[1]++;
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("midreset words before reset", sent, 120);
    rst_n = 1'b0;
    #1;
    check("midreset grant", 32'(bus.o_grant), 32'd0);
    check("midreset valid", 32'(bus.o_valid), 32'd0);
    check("midreset ready", 32'(bus.o_ready), 32'd0);
    check("midreset done", 32'(bus.o_pkt_done), 32'd0);
    @(posedge clk);
    #1;
    drive_sources(4'b0101);
    rst_n = 1'b1;
    #1;
    check("postreset idle grant", 32'(bus.o_grant), 32'd0);
    @(posedge clk);
    #1;
    check("postreset first grant", 32'(bus.o_grant), 32'b0001);
    run_packet("postreset", 0, 4'b0101, NONE, -1, 0, 1'b0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pack_arbiter.md
PACK_ARBITER -- requirements
Module: pack_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of byte-stream requesters.
REQ-002 SHALL have parameter SIZE_INPUT_BIT, default 8, width of one data word.
REQ-003 SHALL have parameter PAYLOAD_WORDS, default 243, payload words per packet (1976-bit packet minus 32-bit preamble, divided by 8).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, starvation limit before padding.
REQ-005 SHALL have parameter FILL_WORD, default 8'h00, padding value.
REQ-006 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port i_reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port i_valid  input  NUM_SRC  per-source data valid.
REQ-009 SHALL have port i_data  input  NUM_SRC*SIZE_INPUT_BIT  per-source data; source k occupies bits [k*SIZE_INPUT_BIT +: SIZE_INPUT_BIT].
REQ-010 SHALL have port o_ready  output  NUM_SRC  per-source accept.
REQ-011 SHALL have port o_data  output  SIZE_INPUT_BIT  word to packer.
REQ-012 SHALL have port o_valid  output  1  word valid to packer.
REQ-013 SHALL have port i_ready_pack  input  1  packer ready.
REQ-014 SHALL have port o_grant  output  NUM_SRC  one-hot current owner; all zero when none.
REQ-015 SHALL have port o_pkt_done  output  1  one-cycle pulse on acceptance of the last word of a packet.
REQ-016 SHALL have port o_padded  output  1  valid with o_pkt_done; 1 if the packet contained fill words.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, XFER, PAD.
REQ-018 A transfer SHALL occur on every cycle with o_valid && i_ready_pack; only transfers SHALL advance the word counter (width $clog2(PAYLOAD_WORDS)).
REQ-019 IDLE: o_grant=0, o_valid=0, o_ready=0; if any i_valid is high, the next source SHALL be chosen round-robin starting at (last_grant+1) mod NUM_SRC, registered into o_grant, counter cleared, and the FSM SHALL move to XFER on the next edge.
REQ-020 XFER: o_data and o_valid SHALL be combinationally muxed from the granted source; o_ready[g] = i_ready_pack, all other o_ready bits SHALL be 0.
REQ-021 XFER: a transfer at counter = PAYLOAD_WORDS-1 SHALL pulse o_pkt_done with o_padded=0, clear o_grant, record last_grant, and return to IDLE.
REQ-022 XFER: the starvation counter SHALL increment on each cycle where the granted i_valid is 0, and clear on any cycle where it is 1; cycles with i_valid=1 and i_ready_pack=0 SHALL NOT count.
REQ-023 XFER: when the starvation counter reaches TIMEOUT_CYCLES, the FSM SHALL enter PAD; the granted source SHALL lose its grant (o_ready all 0).
REQ-024 PAD: o_data=FILL_WORD and o_valid=1; transfers SHALL advance the counter; the transfer at PAYLOAD_WORDS-1 SHALL pulse o_pkt_done with o_padded=1, then IDLE.
REQ-025 A packet SHALL never be cut short: exactly PAYLOAD_WORDS transfers SHALL occur between consecutive o_pkt_done pulses.
REQ-026 A request arriving on the same cycle as o_pkt_done SHALL NOT be granted before the IDLE cycle (one idle cycle minimum between packets).
REQ-027 Requests from non-granted sources SHALL be ignored while in XFER or PAD; no data SHALL be lost (o_ready stays 0).

Reset
REQ-028 On i_reset_n=0: FSM=IDLE, o_grant=0, o_valid=0, o_ready=0, o_pkt_done=0, o_padded=0, counters=0, last_grant=NUM_SRC-1 (source 0 wins first).
REQ-029 Reset mid-XFER or mid-PAD SHALL abandon the packet immediately, with no o_pkt_done.

Verification
REQ-030 Reset asserted with all i_valid=1 -> all outputs 0; after release, o_grant=4'b0001 one cycle later.
REQ-031 Source 0 streams 243 words, i_ready_pack=1 -> 243 transfers, o_pkt_done pulse with o_padded=0, o_grant=0 on the next cycle.
REQ-032 Sources 0 and 2 request continuously -> packets granted 0,2,0,2, each of 243 words, one IDLE cycle between packets.
REQ-033 Source 1 stops after 100 words -> 16 cycles later PAD starts, 143 FILL_WORD transfers, o_pkt_done with o_padded=1.
REQ-034 i_ready_pack=0 for 50 cycles mid-packet with source valid high -> no PAD, o_ready[g]=0, resumes at the same counter value.
REQ-035 i_reset_n pulsed low at word 120 -> outputs 0 asynchronously; the next packet restarts at counter 0 from source 0.
